// File: rtl/mux_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_if
// Description : Bundle for the mux_scan data path. The master drives the
//               control and packed channel data; the slave (mux_scan) returns
//               the registered selection.
//               master -> slave : en, mode, sel, din
//               slave -> master : dout, ch, tick
// Revision    : 1.0  initial release
// ============================================================================
interface mux_scan_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic                      en;    // clock enable, low freezes state
    logic                      mode;  // 0 = manual, 1 = auto-scan
    logic [SEL_W-1:0]          sel;   // manual channel request
    logic [CHANNELS*WIDTH-1:0] din;   // channel k = din[k*WIDTH +: WIDTH]
    logic [WIDTH-1:0]          dout;  // registered selected data
    logic [SEL_W-1:0]          ch;    // channel currently driving dout
    logic                      tick;  // one-cycle pulse when ch changed

    modport master (
        output en, mode, sel, din,
        input  dout, ch, tick
    );

    modport slave (
        input  en, mode, sel, din,
        output dout, ch, tick
    );
endinterface
`default_nettype wire

// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan
// Description : Registered CHANNELS x WIDTH multiplexer with manual select
//               and auto-scan modes. In auto mode the channel steps every
//               DWELL enabled cycles; tick pulses for one cycle whenever the
//               registered channel index changes.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - mux_scan_if.slave (en, mode, sel, din / dout, ch, tick)
// Revision    : 1.0  initial release
// ============================================================================
module mux_scan #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 1000,
    parameter int CNT_W    = 10
) (
    input  wire        clk,
    input  wire        rst_n,
    mux_scan_if.slave  bus
);

    localparam int               c_SLOTS     = 2**SEL_W;
    localparam logic [SEL_W-1:0] c_CH_LAST   = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] c_DWELL_END = CNT_W'(DWELL - 1);

    logic [WIDTH-1:0] r_dout;
    logic [SEL_W-1:0] r_ch;
    logic             r_tick;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode_q;

    // Unpacked view of the inputs, padded to the full select range so any
    // select code indexes a defined slot; w_valid marks real channels.
    logic [WIDTH-1:0]   w_chan [c_SLOTS];
    logic [c_SLOTS-1:0] w_valid;

    for (genvar k = 0; k < c_SLOTS; k++) begin : g_chan
        if (k < CHANNELS) begin : g_used
            assign w_chan[k]  = bus.din[k*WIDTH +: WIDTH];
            assign w_valid[k] = 1'b1;
        end else begin : g_pad
            assign w_chan[k]  = '0;
            assign w_valid[k] = 1'b0;
        end
    end

    logic [SEL_W-1:0] w_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_dout_nxt;

    always_comb begin
        w_nxt     = r_ch;
        w_cnt_nxt = '0;
        if (bus.mode != r_mode_q) begin
            // Mode entry: hold the channel and restart a full dwell period.
            w_nxt     = r_ch;
            w_cnt_nxt = '0;
        end else if (!bus.mode) begin
            // Out-of-range select keeps the current channel.
            w_nxt     = w_valid[bus.sel] ? bus.sel : r_ch;
            w_cnt_nxt = '0;
        end else if (r_cnt == c_DWELL_END) begin
            w_nxt     = (r_ch == c_CH_LAST) ? '0 : r_ch + SEL_W'(1);
            w_cnt_nxt = '0;
        end else begin
            w_nxt     = r_ch;
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    assign w_dout_nxt = w_chan[w_nxt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout   <= '0;
            r_ch     <= '0;
            r_tick   <= 1'b0;
            r_cnt    <= '0;
            r_mode_q <= 1'b0;
        end else if (bus.en) begin
            // dout reloads every enabled edge so it tracks live input data.
            r_dout   <= w_dout_nxt;
            r_ch     <= w_nxt;
            r_tick   <= (w_nxt != r_ch);
            r_cnt    <= w_cnt_nxt;
            r_mode_q <= bus.mode;
        end else begin
            r_tick   <= 1'b0;
        end
    end

    assign bus.dout = r_dout;
    assign bus.ch   = r_ch;
    assign bus.tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan
// Description : Directed self-checking bench for mux_scan. Three instances:
//               u_a (4 ch, DWELL=3), u_b (3 ch, DWELL=3, out-of-range select)
//               and u_c (4 ch, DWELL=1). Control is shared; data is per bus.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mux_scan;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_pass;

    mux_scan_if #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) if_a ();
    mux_scan_if #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) if_b ();
    mux_scan_if #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) if_c ();

    mux_scan #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(3), .CNT_W(2)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    mux_scan #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(3), .CNT_W(2)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    mux_scan #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(1), .CNT_W(1)) u_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_c.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic en, input logic mode, input logic [1:0] sel);
        if_a.en = en;  if_a.mode = mode;  if_a.sel = sel;
        if_b.en = en;  if_b.mode = mode;  if_b.sel = sel;
        if_c.en = en;  if_c.mode = mode;  if_c.sel = sel;
    endtask

    task automatic set_din_a(input logic [15:0] d);
        if_a.din = d;
        if_c.din = d;
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [1:0] ch, input logic [3:0] dout,
                         input logic tick);
        check({tag, ".a.ch"},   32'(if_a.ch),   32'(ch));
        check({tag, ".a.dout"}, 32'(if_a.dout), 32'(dout));
        check({tag, ".a.tick"}, 32'(if_a.tick), 32'(tick));
    endtask

    initial begin
        logic [3:0] a_nib [4];   // channel values of 16'hD9A3
        logic [1:0] exp_ch;

        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 2'd0);
        set_din_a(16'h0000);
        if_b.din = 12'h000;

        #2;
        chk_a("rst0", 2'd0, 4'h0, 1'b0);

        #10;                        // t=12, between edges
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 2'd2);
        set_din_a(16'hD5A3);
        if_b.din = 12'h321;

        // Manual select
        step();
        chk_a("man_sel", 2'd2, 4'h5, 1'b1);
        check("man_sel.b.dout", 32'(if_b.dout), 32'h3);
        step();
        chk_a("man_hold", 2'd2, 4'h5, 1'b0);
        set_din_a(16'hD9A3);
        step();
        chk_a("man_live", 2'd2, 4'h9, 1'b0);

        // Asynchronous reset with dout nonzero, no clock edge in between
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("arst", 2'd0, 4'h0, 1'b0);
        check("arst.b.ch", 32'(if_b.ch), 32'd0);
        check("arst.c.dout", 32'(if_c.dout), 32'h0);
        #2;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 2'd1);

        // Out-of-range select on the 3-channel instance
        step();
        chk_a("sel1", 2'd1, 4'hA, 1'b1);
        check("sel1.b.ch",   32'(if_b.ch),   32'd1);
        check("sel1.b.dout", 32'(if_b.dout), 32'h2);
        check("sel1.b.tick", 32'(if_b.tick), 32'd1);
        drive(1'b1, 1'b0, 2'd3);
        if_b.din = 12'h351;
        step();
        check("oor.b.ch",   32'(if_b.ch),   32'd1);
        check("oor.b.tick", 32'(if_b.tick), 32'd0);
        check("oor.b.dout", 32'(if_b.dout), 32'h5);
        chk_a("sel3", 2'd3, 4'hD, 1'b1);

        // Auto scan from ch=0
        drive(1'b1, 1'b0, 2'd0);
        step();
        chk_a("sel0", 2'd0, 4'h3, 1'b1);
        a_nib[0] = 4'h3; a_nib[1] = 4'hA; a_nib[2] = 4'h9; a_nib[3] = 4'hD;
        drive(1'b1, 1'b1, 2'd0);
        for (int i = 0; i <= 12; i++) begin
            step();
            exp_ch = 2'((i / 3) % 4);
            chk_a($sformatf("auto%0d", i), exp_ch, a_nib[exp_ch],
                  (i > 0) && (i % 3 == 0));
            check($sformatf("auto%0d.c.ch", i),   32'(if_c.ch),   32'(i % 4));
            check($sformatf("auto%0d.c.tick", i), 32'(if_c.tick), 32'(i > 0));
        end

        // Enable gating at cnt=1
        step();
        chk_a("cnt1", 2'd0, 4'h3, 1'b0);
        drive(1'b0, 1'b1, 2'd0);
        set_din_a(16'hD9A7);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_a($sformatf("gate%0d", i), 2'd0, 4'h3, 1'b0);
            check($sformatf("gate%0d.c.tick", i), 32'(if_c.tick), 32'd0);
        end
        drive(1'b1, 1'b1, 2'd0);
        step();
        chk_a("ungate1", 2'd0, 4'h7, 1'b0);
        step();
        chk_a("ungate2", 2'd1, 4'hA, 1'b1);

        // Move to ch=2 with cnt=1, then manual and back to auto
        step();
        step();
        step();
        chk_a("to_ch2", 2'd2, 4'h9, 1'b1);
        step();
        chk_a("ch2_cnt1", 2'd2, 4'h9, 1'b0);
        drive(1'b1, 1'b0, 2'd2);
        step();
        chk_a("sw_man", 2'd2, 4'h9, 1'b0);
        drive(1'b1, 1'b1, 2'd2);
        step();
        chk_a("sw_auto", 2'd2, 4'h9, 1'b0);
        step();
        chk_a("reauto1", 2'd2, 4'h9, 1'b0);
        step();
        chk_a("reauto2", 2'd2, 4'h9, 1'b0);
        step();
        chk_a("reauto3", 2'd3, 4'hD, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
